// File: rtl/tx_port_monitor_gen_if.sv
// Bundle of gate-FIFO, output-buffer and transaction-parameter signals around the TX monitor.
// Latency: none, wiring only.
// Backpressure: carried by EVT_DATA_EMPTY/EVT_DATA_RD_EN, WR_COUNT and ACK.
interface tx_port_monitor_gen_if #(
   parameter int C_DATA_WIDTH = 128,
   parameter int C_FIFO_DEPTH = 512
);
   localparam int C_WORDS            = C_DATA_WIDTH / 32;
   localparam int C_WORDS_WIDTH      = $clog2(C_WORDS) + 1;
   localparam int C_FIFO_DEPTH_WIDTH = $clog2((2 ** $clog2(C_FIFO_DEPTH)) + 1);

   logic [C_DATA_WIDTH:0]         EVT_DATA;
   logic                          EVT_DATA_EMPTY;
   logic                          EVT_DATA_RD_EN;
   logic [C_DATA_WIDTH-1:0]       WR_DATA;
   logic                          WR_EN;
   logic [C_WORDS_WIDTH-1:0]      WR_WORDS;
   logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT;
   logic                          TXN;
   logic                          ACK;
   logic                          LAST;
   logic [30:0]                   OFF;
   logic [31:0]                   LEN;
   logic [31:0]                   WORDS_RECVD;
   logic                          DONE;
   logic                          ERR;
   logic                          TX_ERR;

   // The monitor itself
   modport master (
      input  EVT_DATA, EVT_DATA_EMPTY, WR_COUNT, ACK, TX_ERR,
      output EVT_DATA_RD_EN, WR_DATA, WR_EN, WR_WORDS, TXN, LAST, OFF, LEN,
             WORDS_RECVD, DONE, ERR
   );

   // The gate FIFO, output buffer and transaction consumer
   modport slave (
      output EVT_DATA, EVT_DATA_EMPTY, WR_COUNT, ACK, TX_ERR,
      input  EVT_DATA_RD_EN, WR_DATA, WR_EN, WR_WORDS, TXN, LAST, OFF, LEN,
             WORDS_RECVD, DONE, ERR
   );
endinterface

// File: rtl/tx_port_monitor_gen.sv
// TX transaction monitor: pairs open/close events, offers parameters for ACK, forwards LEN words of payload.
// Latency: payload beat reaches WR_EN in the cycle its read data is valid (one cycle after the read).
// Backpressure: stops reading while parameters await ACK or the output FIFO is within C_FIFO_SLACK of full.
module tx_port_monitor_gen #(
   parameter int C_DATA_WIDTH = 128,
   parameter int C_FIFO_DEPTH = 512,
   parameter int C_FIFO_SLACK = 4
) (
   input logic                   CLK,
   input logic                   RST,
   tx_port_monitor_gen_if.master bus
);
   localparam int C_WORDS            = C_DATA_WIDTH / 32;
   localparam int C_WORDS_WIDTH      = $clog2(C_WORDS) + 1;
   localparam int C_FIFO_DEPTH_WIDTH = $clog2((2 ** $clog2(C_FIFO_DEPTH)) + 1);

   localparam logic [C_FIFO_DEPTH_WIDTH-1:0] AF_LEVEL = C_FIFO_DEPTH_WIDTH'(C_FIFO_DEPTH - C_FIFO_SLACK);
   localparam logic [31:0]                   WORDS_32 = 32'(C_WORDS);

   typedef enum logic [2:0] {
      S_NEXT  = 3'd0,
      S_EVT_2 = 3'd1,
      S_TXN   = 3'd2,
      S_READ  = 3'd3,
      S_END_0 = 3'd4,
      S_END_1 = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic        rd_en;
   logic        r_valid;
   logic        r_event;
   logic        r_tx_err;
   logic        r_af;
   logic [31:0] txn_len;
   logic [30:0] txn_off;
   logic        txn_last;
   logic [31:0] words_recvd;
   logic [31:0] remain;
   logic        err_flag;

   logic        event_beat;
   logic        payload_beat;
   logic        rd_en_nxt;
   logic        capture;
   logic        start;
   logic        wr_en;
   logic        err_set;
   logic [C_WORDS_WIDTH-1:0] wr_words;
   logic [31:0] beat_words;

   assign event_beat   = r_valid &  bus.EVT_DATA[C_DATA_WIDTH];
   assign payload_beat = r_valid & ~bus.EVT_DATA[C_DATA_WIDTH];

   // Final beat carries only what is left of LEN; earlier beats are full.
   assign wr_words   = (remain < WORDS_32) ? remain[C_WORDS_WIDTH-1:0] : C_WORDS_WIDTH'(C_WORDS);
   assign beat_words = 32'(wr_words);

   // In EVT_2 the duplicate is normally already in flight, so no extra read is issued for it.
   assign rd_en_nxt = (state != S_TXN) & ~r_af & ~event_beat &
                      ~((state == S_EVT_2) & (r_event | event_beat | ~bus.EVT_DATA_EMPTY));

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state <= S_NEXT;
      else     state <= state_nxt;
   end

   // Next state and per-cycle strobes
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      start     = 1'b0;
      wr_en     = 1'b0;
      err_set   = 1'b0;
      case (state)
         S_NEXT: begin
            // Payload seen here is stale data from an aborted transaction.
            if (event_beat) begin
               capture   = 1'b1;
               state_nxt = S_EVT_2;
            end
         end
         S_EVT_2: begin
            if (event_beat) state_nxt = S_TXN;
         end
         S_TXN: begin
            if (bus.ACK) begin
               start     = 1'b1;
               state_nxt = (txn_len == 32'd0) ? S_END_0 : S_READ;
            end
         end
         S_READ: begin
            wr_en = payload_beat;
            if (event_beat)
               state_nxt = S_END_1;
            else if (payload_beat && (remain <= WORDS_32))
               state_nxt = S_END_0;
            else if (r_tx_err) begin
               state_nxt = S_END_0;
               err_set   = 1'b1;
            end
         end
         S_END_0: begin
            err_set = payload_beat;
            if (event_beat) state_nxt = S_END_1;
         end
         S_END_1: begin
            err_set = payload_beat;
            if (event_beat) state_nxt = S_NEXT;
         end
         default: state_nxt = S_NEXT;
      endcase
   end

   // Read pipeline, input registers and transaction bookkeeping
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_en       <= 1'b0;
         r_valid     <= 1'b0;
         r_event     <= 1'b0;
         r_tx_err    <= 1'b0;
         r_af        <= 1'b0;
         txn_len     <= 32'd0;
         txn_off     <= 31'd0;
         txn_last    <= 1'b0;
         words_recvd <= 32'd0;
         remain      <= 32'd0;
         err_flag    <= 1'b0;
      end else begin
         rd_en    <= rd_en_nxt;
         r_valid  <= rd_en & ~bus.EVT_DATA_EMPTY;
         r_event  <= event_beat;
         r_tx_err <= bus.TX_ERR;
         r_af     <= (bus.WR_COUNT >= AF_LEVEL);
         if (capture) begin
            txn_len  <= bus.EVT_DATA[63:32];
            txn_off  <= bus.EVT_DATA[31:1];
            txn_last <= bus.EVT_DATA[0];
         end
         if (start) begin
            words_recvd <= 32'd0;
            remain      <= txn_len;
            err_flag    <= 1'b0;
         end else begin
            if (wr_en) begin
               words_recvd <= words_recvd + beat_words;
               remain      <= remain - beat_words;
            end
            if (err_set) err_flag <= 1'b1;
         end
      end
   end

   assign bus.EVT_DATA_RD_EN = rd_en;
   assign bus.WR_DATA        = bus.EVT_DATA[C_DATA_WIDTH-1:0];
   assign bus.WR_EN          = wr_en;
   assign bus.WR_WORDS       = wr_words;
   assign bus.TXN            = (state == S_TXN);
   assign bus.LAST           = txn_last;
   assign bus.OFF            = txn_off;
   assign bus.LEN            = txn_len;
   assign bus.WORDS_RECVD    = words_recvd;
   assign bus.DONE           = (state != S_READ);
   assign bus.ERR            = err_flag;
endmodule

// File: tb/tb_tx_port_monitor_gen.sv
// Bench for tx_port_monitor_gen: gate-FIFO model, transaction-level reference and write scoreboard.
// Latency: n/a.
// Backpressure: WR_COUNT is driven to the almost-full level in one scenario.
module tb_tx_port_monitor_gen;
   localparam int DW    = 128;
   localparam int DEPTH = 512;
   localparam int SLACK = 4;
   localparam int W     = DW / 32;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   tx_port_monitor_gen_if #(.C_DATA_WIDTH(DW), .C_FIFO_DEPTH(DEPTH)) bus ();

   tx_port_monitor_gen #(.C_DATA_WIDTH(DW), .C_FIFO_DEPTH(DEPTH), .C_FIFO_SLACK(SLACK)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Gate FIFO model: data appears on EVT_DATA the cycle after a non-empty read.
   logic [DW:0] gate_mem [0:1023];
   logic [9:0]  wr_ptr = '0;
   logic [9:0]  rd_ptr = '0;
   logic [DW:0] evt_q  = '0;
   logic        flush  = 1'b0;
   assign bus.EVT_DATA       = evt_q;
   assign bus.EVT_DATA_EMPTY = (wr_ptr == rd_ptr);

   always @(posedge CLK) begin
      if (flush) rd_ptr <= wr_ptr;
      else if (bus.EVT_DATA_RD_EN && (wr_ptr != rd_ptr)) begin
         evt_q  <= gate_mem[rd_ptr];
         rd_ptr <= rd_ptr + 10'd1;
      end
   end

   task automatic push(input logic flag, input logic [DW-1:0] d);
      gate_mem[wr_ptr] = {flag, d};
      wr_ptr = wr_ptr + 10'd1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard of expected writes
   typedef struct {
      logic [2:0]    words;
      logic [DW-1:0] data;
      logic          last;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   int   wr_seen = 0;
   int   pend    = 0;   // 1: DONE must be high now, 2: DONE must be low now
   logic mon_off = 1'b1;

   always @(posedge CLK) begin
      #2;
      if (mon_off) pend = 0;
      else begin
         if (pend == 1) check_val("done_after_last", DW'(bus.DONE), DW'(1));
         if (pend == 2) check_val("done_mid_read", DW'(bus.DONE), DW'(0));
         pend = 0;
         if (bus.WR_EN) begin
            wr_seen++;
            if (exp_q.size() == 0) check_val("unexp_wr", DW'(bus.WR_EN), DW'(0));
            else begin
               mon_e = exp_q.pop_front();
               check_val("wr_words", DW'(bus.WR_WORDS), DW'(mon_e.words));
               check_val("wr_data", bus.WR_DATA, mon_e.data);
               pend = mon_e.last ? 1 : 2;
            end
         end
      end
   end

   task automatic check_reset();
      check_val("rst_rd_en", DW'(bus.EVT_DATA_RD_EN), DW'(0));
      check_val("rst_wr_en", DW'(bus.WR_EN), DW'(0));
      check_val("rst_txn", DW'(bus.TXN), DW'(0));
      check_val("rst_err", DW'(bus.ERR), DW'(0));
      check_val("rst_words", DW'(bus.WORDS_RECVD), DW'(0));
      check_val("rst_len", DW'(bus.LEN), DW'(0));
      check_val("rst_off", DW'(bus.OFF), DW'(0));
      check_val("rst_last", DW'(bus.LAST), DW'(0));
      check_val("rst_done", DW'(bus.DONE), DW'(1));
   endtask

   task automatic open_ack(input logic [31:0] len, input logic [30:0] off, input logic last, input int ack_dly);
      logic [DW-1:0] d;
      int t;
      d = rnd_data();
      d[63:0] = {len, off, last};
      @(negedge CLK);
      push(1'b1, d);
      push(1'b1, d);
      t = 0;
      while (!bus.TXN && t < 100) begin @(negedge CLK); t++; end
      check_val("txn_up", DW'(bus.TXN), DW'(1));
      check_val("txn_len", DW'(bus.LEN), DW'(len));
      check_val("txn_off", DW'(bus.OFF), DW'(off));
      check_val("txn_last", DW'(bus.LAST), DW'(last));
      check_val("txn_done", DW'(bus.DONE), DW'(1));
      repeat (ack_dly) @(negedge CLK);
      check_val("txn_hold", DW'(bus.TXN), DW'(1));
      bus.ACK = 1'b1;
      @(negedge CLK);
      bus.ACK = 1'b0;
      check_val("ack_txn", DW'(bus.TXN), DW'(0));
      check_val("ack_words", DW'(bus.WORDS_RECVD), DW'(0));
      check_val("ack_err", DW'(bus.ERR), DW'(0));
      check_val("ack_done", DW'(bus.DONE), DW'(len == 32'd0));
   endtask

   // Reference: the first ceil(LEN/W) payload beats are written, the last one partially; any more overflow.
   task automatic send_payload(input logic [31:0] len, input int p, input int gap_max,
                               output logic [31:0] exp_words, output logic exp_err);
      int nb;
      logic [31:0] rem;
      logic [DW-1:0] d;
      exp_t e;
      nb = int'((len + 32'(W) - 32'd1) / 32'(W));
      rem = len;
      exp_words = 32'd0;
      exp_err = 1'b0;
      for (int i = 0; i < p; i++) begin
         d = rnd_data();
         if (i < nb) begin
            e.words = (rem < 32'(W)) ? rem[2:0] : 3'(W);
            e.data  = d;
            e.last  = (i == nb - 1);
            exp_q.push_back(e);
            exp_words += 32'(e.words);
            rem -= 32'(e.words);
         end else exp_err = 1'b1;
         push(1'b0, d);
         repeat ($urandom_range(0, gap_max)) @(negedge CLK);
      end
   endtask

   task automatic close_check(input logic [31:0] exp_words, input logic exp_err);
      logic [DW-1:0] d;
      int t;
      d = rnd_data();
      push(1'b1, d);
      push(1'b1, d);
      t = 0;
      while (!bus.EVT_DATA_EMPTY && t < 500) begin @(negedge CLK); t++; end
      check_val("drain", DW'(bus.EVT_DATA_EMPTY), DW'(1));
      repeat (8) @(negedge CLK);
      check_val("end_done", DW'(bus.DONE), DW'(1));
      check_val("end_words", DW'(bus.WORDS_RECVD), DW'(exp_words));
      check_val("end_err", DW'(bus.ERR), DW'(exp_err));
      check_val("end_pending", DW'(exp_q.size()), DW'(0));
   endtask

   task automatic wait_writes(input int target, input string tag);
      int t;
      t = 0;
      while (wr_seen < target && t < 300) begin @(negedge CLK); t++; end
      check_val(tag, DW'(wr_seen >= target), DW'(1));
   endtask

   task automatic run_txn(input logic [31:0] len, input int p, input int gap_max);
      logic [31:0] ew;
      logic ee;
      open_ack(len, 31'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      send_payload(len, p, gap_max, ew, ee);
      close_check(ew, ee);
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
      $fatal(1);
   end

   initial begin
      logic [31:0] ew;
      logic ee;
      int snap;
      bus.ACK      = 1'b0;
      bus.TX_ERR   = 1'b0;
      bus.WR_COUNT = '0;
      repeat (3) @(negedge CLK);
      check_reset();
      RST = 1'b0;
      mon_off = 1'b0;

      // Basic transaction, LEN=10 -> 4,4,2
      open_ack(32'd10, 31'h40, 1'b1, 3);
      send_payload(32'd10, 3, 1, ew, ee);
      close_check(ew, ee);
      check_val("t1_words", DW'(bus.WORDS_RECVD), DW'(10));

      // LEN=0: no writes
      run_txn(32'd0, 0, 0);
      // Overflow: third beat beyond LEN=8
      run_txn(32'd8, 3, 1);
      check_val("t3_err", DW'(bus.ERR), DW'(1));
      // ERR clears on the next ACK (checked inside open_ack); early close
      run_txn(32'd16, 2, 0);

      // Almost-full throttling
      open_ack(32'd200, 31'h123, 1'b0, 1);
      send_payload(32'd200, 50, 0, ew, ee);
      wait_writes(wr_seen + 5, "af_pre");
      bus.WR_COUNT = 10'(DEPTH - SLACK);
      snap = wr_seen;
      @(negedge CLK);
      @(negedge CLK);
      check_val("af_rd_off", DW'(bus.EVT_DATA_RD_EN), DW'(0));
      repeat (10) @(negedge CLK);
      check_val("af_slack", DW'((wr_seen - snap) <= 2), DW'(1));
      check_val("af_hold", DW'(bus.EVT_DATA_RD_EN), DW'(0));
      bus.WR_COUNT = '0;
      @(negedge CLK);
      @(negedge CLK);
      check_val("af_resume", DW'(bus.EVT_DATA_RD_EN), DW'(1));
      close_check(ew, ee);

      // TX_ERR abort after two beats of LEN=64
      open_ack(32'd64, 31'h7, 1'b0, 0);
      send_payload(32'd64, 2, 0, ew, ee);
      wait_writes(wr_seen + 2, "err_pre");
      @(negedge CLK);
      bus.TX_ERR = 1'b1;
      @(negedge CLK);
      bus.TX_ERR = 1'b0;
      repeat (3) @(negedge CLK);
      check_val("txerr_err", DW'(bus.ERR), DW'(1));
      check_val("txerr_done", DW'(bus.DONE), DW'(1));
      check_val("txerr_words", DW'(bus.WORDS_RECVD), DW'(8));
      push(1'b0, rnd_data());
      close_check(32'd8, 1'b1);

      // Reset in the middle of READ
      open_ack(32'd64, 31'h55, 1'b1, 0);
      send_payload(32'd64, 16, 0, ew, ee);
      wait_writes(wr_seen + 3, "rst_pre");
      @(negedge CLK);
      mon_off = 1'b1;
      RST = 1'b1;
      flush = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      flush = 1'b0;
      check_reset();
      exp_q.delete();
      mon_off = 1'b0;
      run_txn(32'd12, 3, 1);

      // Randomized transactions, some preceded by stale payload
      for (int k = 0; k < 30; k++) begin
         logic [31:0] len;
         int nb;
         len = 32'($urandom_range(0, 40));
         nb  = int'((len + 32'(W) - 32'd1) / 32'(W));
         bus.WR_COUNT = 10'($urandom_range(0, 400));
         if ($urandom_range(0, 3) == 0) push(1'b0, rnd_data());
         run_txn(len, $urandom_range(0, nb + 2), 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
